uart_iomem: RTL

- Memory-mapped UART responder on the picosoc iomem peripheral bus; picosoc is the initiator.
- Decodes a small register window inside its enable region (the top level gates iomem_valid with its address decode).
- Returns a proper iomem_ready/iomem_rdata handshake, serialises TX bytes onto ser_tx and deserialises ser_rx into an RX FIFO.
- Raises a level interrupt to a picosoc irq line while received data is pending.

---
 rtl/uart_iomem_pkg.sv | 34 +++
 rtl/uart_iomem_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_iomem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_iomem_pkg.sv
// Shared constants, register map and FSM state types for the picosoc iomem UART.
package uart_iomem_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  localparam int unsigned ST_RX_NONEMPTY  = 0;
  localparam int unsigned ST_TX_BUSY      = 1;
  localparam int unsigned ST_RX_FULL      = 2;
  localparam int unsigned ST_OVERRUN      = 3;
  localparam int unsigned ST_FRAME_ERR    = 4;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned RX_COUNT_W      = 5;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

  localparam logic [DIV_W-1:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divider values below MIN_DIV would leave no room for a mid-bit RX sample.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_iomem_if.sv
// picosoc iomem bus between the SoC (master) and a peripheral (slave).
interface uart_iomem_if;
  import uart_iomem_pkg::*;

  logic              iomem_valid;
  logic              iomem_ready;
  logic [STRB_W-1:0] iomem_wstrb;
  logic [BUS_W-1:0]  iomem_addr;
  logic [BUS_W-1:0]  iomem_wdata;
  logic [BUS_W-1:0]  iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; a push while full is dropped and flagged on dropped_c.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [CNT_W-1:0]  count,
  output logic              dropped_c
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok_c;
  logic              pop_ok_c;

  // Fullness is judged on the registered count, before any same-cycle pop.
  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign push_ok_c  = push & ~full_c;
  assign pop_ok_c   = pop & ~empty_c;
  assign dropped_c  = push & full_c;
  assign pop_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    end
  end

endmodule

// File: rtl/uart_iomem.sv
// Memory-mapped UART on the picosoc iomem bus: TX serialiser, RX deserialiser
// feeding a FIFO, sticky error flags and a level irq while RX data is pending.
module uart_iomem
  import uart_iomem_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 139,
  parameter int unsigned RX_DEPTH    = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_iomem_if.slave  bus,
  output logic         ser_tx,
  input  logic         ser_rx,
  output logic         irq
);

  localparam int unsigned CNT_W = $clog2(RX_DEPTH) + 1;

  logic [DIV_W-1:0]  clkdiv;
  logic              overrun;
  logic              frame_err;

  logic [1:0]        reg_sel_c;
  logic              is_read_c;
  logic              tx_wr_c;
  logic              tx_busy_c;
  logic              accept_c;
  logic              pop_c;
  logic              w1c_c;
  logic              div_wr_c;
  logic [DIV_W-1:0]  div_wr_val_c;
  logic [DIV_W-1:0]  div_m1_c;
  logic [DIV_W-1:0]  half_m1_c;
  logic [BUS_W-1:0]  status_c;
  logic [BUS_W-1:0]  rd_val_c;
  logic [RX_COUNT_W-1:0] rx_count_c;

  logic [BYTE_W-1:0] fifo_rdata_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_drop_c;

  tx_state_e         tx_state;
  logic [DIV_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [BYTE_W-1:0] tx_shift;

  rx_state_e         rx_state;
  logic [DIV_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [BYTE_W-1:0] rx_shift;
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_prev;
  logic              rx_fall_c;
  logic              rx_tick_c;
  logic              rx_push_c;
  logic              rx_ferr_c;

  logic              unused_c;

  assign unused_c = ^{bus.iomem_addr[BUS_W-1:4], bus.iomem_addr[1:0],
                      bus.iomem_wdata[BUS_W-1:DIV_W], bus.iomem_wstrb[STRB_W-1:2]};

  // Bus decode; a TX enqueue while the shifter is busy is held off, not accepted.
  assign reg_sel_c = bus.iomem_addr[3:2];
  assign is_read_c = (bus.iomem_wstrb == '0);
  assign tx_busy_c = (tx_state != TX_IDLE);
  assign tx_wr_c   = ~is_read_c & (reg_sel_c == REG_DATA) & bus.iomem_wstrb[0];
  assign accept_c  = bus.iomem_valid & ~bus.iomem_ready & ~(tx_wr_c & tx_busy_c);
  assign pop_c     = accept_c & is_read_c & (reg_sel_c == REG_DATA) & ~fifo_empty_c;
  assign w1c_c     = accept_c & ~is_read_c & (reg_sel_c == REG_STATUS) & bus.iomem_wstrb[0];
  assign div_wr_c  = accept_c & ~is_read_c & (reg_sel_c == REG_CLKDIV) & (|bus.iomem_wstrb[1:0]);

  assign div_wr_val_c = {bus.iomem_wstrb[1] ? bus.iomem_wdata[15:8] : clkdiv[15:8],
                         bus.iomem_wstrb[0] ? bus.iomem_wdata[7:0]  : clkdiv[7:0]};
  assign div_m1_c  = clkdiv - DIV_W'(1);
  assign half_m1_c = (clkdiv >> 1) - DIV_W'(1);

  assign rx_count_c = (32'(fifo_count) > 32'd31) ? RX_COUNT_W'(31) : RX_COUNT_W'(fifo_count);

  always_comb begin
    status_c = '0;
    status_c[ST_RX_NONEMPTY] = ~fifo_empty_c;
    status_c[ST_TX_BUSY]     = tx_busy_c;
    status_c[ST_RX_FULL]     = fifo_full_c;
    status_c[ST_OVERRUN]     = overrun;
    status_c[ST_FRAME_ERR]   = frame_err;
    status_c[ST_RX_COUNT_LSB +: RX_COUNT_W] = rx_count_c;
  end

  always_comb begin
    rd_val_c = '0;
    case (reg_sel_c)
      REG_DATA:   rd_val_c = fifo_empty_c ? 32'hFFFF_FFFF : {24'h0, fifo_rdata_c};
      REG_STATUS: rd_val_c = status_c;
      REG_CLKDIV: rd_val_c = {16'h0, clkdiv};
      default:    rd_val_c = '0;
    endcase
  end

  // Completion pulse and read data, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= accept_c;
      bus.iomem_rdata <= (accept_c & is_read_c) ? rd_val_c : '0;
    end
  end

  // Control registers; a new error event wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkdiv    <= DIV_W'(DEFAULT_DIV);
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (div_wr_c) begin
        clkdiv <= clamp_div(div_wr_val_c);
      end
      if (fifo_drop_c) begin
        overrun <= 1'b1;
      end else if (w1c_c & bus.iomem_wdata[ST_OVERRUN]) begin
        overrun <= 1'b0;
      end
      if (rx_ferr_c) begin
        frame_err <= 1'b1;
      end else if (w1c_c & bus.iomem_wdata[ST_FRAME_ERR]) begin
        frame_err <= 1'b0;
      end
      irq <= ~fifo_empty_c;
    end
  end

  // TX shifter: each bit reloads the divider, so CLKDIV changes land on bit boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      ser_tx   <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (accept_c & tx_wr_c) begin
            tx_state <= TX_START;
            ser_tx   <= 1'b0;
            tx_cnt   <= div_m1_c;
            tx_shift <= bus.iomem_wdata[BYTE_W-1:0];
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            ser_tx   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= div_m1_c;
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= div_m1_c;
            if (tx_bit == 3'(DATA_BITS - 1)) begin
              tx_state <= TX_STOP;
              ser_tx   <= 1'b1;
            end else begin
              ser_tx   <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_fall_c = rx_prev & ~rx_s2;
  assign rx_tick_c = (rx_cnt == '0);
  assign rx_push_c = (rx_state == RX_STOP) & rx_tick_c & rx_s2;
  assign rx_ferr_c = (rx_state == RX_STOP) & rx_tick_c & ~rx_s2;

  // RX: synchroniser, then half-bit start qualification and mid-bit sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= ser_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall_c) begin
            rx_state <= RX_START;
            rx_cnt   <= half_m1_c;
          end
        end
        RX_START: begin
          if (rx_tick_c) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
              rx_cnt   <= div_m1_c;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick_c) begin
            rx_shift <= {rx_s2, rx_shift[BYTE_W-1:1]};
            rx_cnt   <= div_m1_c;
            if (rx_bit == 3'(DATA_BITS - 1)) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick_c) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH  (RX_DEPTH),
    .DATA_W (BYTE_W)
  ) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_push_c),
    .push_data  (rx_shift),
    .pop        (pop_c),
    .pop_data_c (fifo_rdata_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c),
    .count      (fifo_count),
    .dropped_c  (fifo_drop_c)
  );

endmodule
